// File: rtl/jk_arb_pkg.sv
// Shared op codes, FSM states and the JK next-value helper for the bank arbiter.
package jk_arb_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARB    = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  // Next value of one JK bit given its {J,K} command.
  function automatic logic jk_next(input logic [1:0] op, input logic cur);
    case (op)
      JK_CLR:  return 1'b0;
      JK_SET:  return 1'b1;
      JK_TGL:  return ~cur;
      default: return cur;
    endcase
  endfunction

endpackage

// File: rtl/jk_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after ptr.
module jk_rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any_valid
);

  // Winner is the valid requester with the smallest rotational distance from ptr.
  always_comb begin
    int best_d;
    int best_j;
    int d;
    best_d = int'(N);
    best_j = 0;
    d      = 0;
    for (int j = 0; j < int'(N); j++) begin
      if (valid[j]) begin
        d = (j + int'(N) - int'(ptr)) % int'(N);
        if (d < best_d) begin
          best_d = d;
          best_j = j;
        end
      end
    end
    any_valid = |valid;
    grant     = any_valid ? (N'(1) << best_j) : '0;
    grant_idx = PW'(best_j);
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// JK bit bank shared by N_REQ requesters through a round-robin arbiter with lock.
// Optional JK_ARB_PRIO_EN: requester 0 gets fixed priority and may preempt a lock once.
module jk_bank_arbiter
  import jk_arb_pkg::*;
#(
  parameter  int unsigned N_REQ  = 4,
  parameter  int unsigned N_BITS = 8,
  localparam int unsigned IDX_W  = $clog2(N_BITS),
  localparam int unsigned PTR_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_lock,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [IDX_W*N_REQ-1:0] req_idx,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_BITS-1:0]      q,
  output logic [2:0]             grant_id,
  output logic                   busy
);

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
`ifdef JK_ARB_PRIO_EN
  logic             pre_q, pre_d;
  logic             prio_ok;
`endif

  logic [N_REQ-1:0] rr_grant;
  logic [PTR_W-1:0] rr_idx;
  logic             rr_any;
  logic [N_REQ-1:0] own_vec;
  logic [N_REQ-1:0] acc_vec;
  logic             accept;
  logic             own_valid;
  logic             own_lock;
  logic [1:0]       sel_op;
  logic [IDX_W-1:0] sel_idx;
  logic [PTR_W-1:0] sel_id;
  logic             sel_lock;

  logic [1:0]       pend_op_q;
  logic [IDX_W-1:0] pend_idx_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] x);
    return (int'(x) == int'(N_REQ) - 1) ? '0 : PTR_W'(int'(x) + 1);
  endfunction

  jk_rr_arbiter #(.N(N_REQ)) u_rr (
    .valid     (req_valid),
    .ptr       (ptr_q),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .any_valid (rr_any)
  );

  assign own_vec = N_REQ'(1) << owner_q;

  // Ready generation, accepted-command mux and next-state logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    req_ready = '0;
    sel_op    = JK_HOLD;
    sel_idx   = '0;
    sel_id    = '0;
    sel_lock  = 1'b0;
`ifdef JK_ARB_PRIO_EN
    pre_d     = 1'b0;
    prio_ok   = (state_q != LOCKED) || ((owner_q != '0) && !pre_q);
`endif

    case (state_q)
      IDLE, ARB: req_ready = rr_grant;
      LOCKED:    req_ready = req_valid & own_vec;
      default:   req_ready = '0;
    endcase
`ifdef JK_ARB_PRIO_EN
    if (req_valid[0] && prio_ok) req_ready = N_REQ'(1);
`endif

    acc_vec   = req_valid & req_ready;
    accept    = |acc_vec;
    own_valid = |(req_valid & own_vec);
    own_lock  = |(req_lock & own_vec);
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (acc_vec[i]) begin
        sel_op   = req_op[2*i +: 2];
        sel_idx  = req_idx[IDX_W*i +: IDX_W];
        sel_id   = PTR_W'(i);
        sel_lock = req_lock[i];
      end
    end

    case (state_q)
      IDLE, ARB: begin
`ifdef JK_ARB_PRIO_EN
        if (accept && (sel_id != '0)) ptr_d = ptr_inc(rr_idx);
`else
        if (accept) ptr_d = ptr_inc(rr_idx);
`endif
        if (accept && sel_lock) begin
          state_d = LOCKED;
          owner_d = sel_id;
        end else if (rr_any) begin
          state_d = ARB;
        end else begin
          state_d = IDLE;
        end
      end
      LOCKED: begin
        if (accept && (sel_id == owner_q)) begin
          if (!sel_lock) state_d = ARB;
        end else if (!accept && !own_valid && !own_lock) begin
          state_d = ARB;
        end
`ifdef JK_ARB_PRIO_EN
        // One preemption per owner command: set on a req0 win, cleared when the owner is served.
        pre_d = accept ? (sel_id != owner_q) : pre_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, round-robin pointer and lock owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
`ifdef JK_ARB_PRIO_EN
      pre_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
`ifdef JK_ARB_PRIO_EN
      pre_q   <= pre_d;
`endif
    end
  end

  // Apply stage and bank; out-of-range indices match no bit and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      pend_op_q  <= JK_HOLD;
      pend_idx_q <= '0;
      grant_id   <= '0;
      q          <= '0;
    end else begin
      busy <= accept;
      if (accept) begin
        pend_op_q  <= sel_op;
        pend_idx_q <= sel_idx;
        grant_id   <= 3'(sel_id);
      end
      for (int b = 0; b < int'(N_BITS); b++) begin
        if (busy && (pend_idx_q == IDX_W'(b))) q[b] <= jk_next(pend_op_q, q[b]);
      end
    end
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Self-checking bench for jk_bank_arbiter: vector table, directed corner sequences, random vs model.
module tb_jk_bank_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_lock;
  logic [7:0]  req_op;
  logic [11:0] req_idx;
  logic [3:0]  req_ready;
  logic [7:0]  q;
  logic [2:0]  grant_id;
  logic        busy;

  int total = 0;
  int bad   = 0;

  jk_bank_arbiter #(.N_REQ(4), .N_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_op    (req_op),
    .req_idx   (req_idx),
    .req_ready (req_ready),
    .q         (q),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: lock owner, rotating pointer, bank bits and a one-deep apply slot.
  bit         m_locked;
  int         m_owner;
  int         m_ptr;
  bit         m_pre;
  logic [7:0] m_q;
  bit         m_pend;
  logic [1:0] m_pop;
  int         m_pidx;
  int         m_gid;
  logic [3:0] last_ready;

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0; m_pre = 0;
    m_q = 8'h00; m_pend = 0; m_pop = 2'b00; m_pidx = 0; m_gid = 0;
  endtask

  function automatic logic [3:0] model_ready(input logic [3:0] v);
    logic [3:0] r;
    r = 4'b0000;
    if (m_locked) begin
      if (v[m_owner]) r[m_owner] = 1'b1;
    end else begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (v[c] && r == 4'b0000) r[c] = 1'b1;
      end
    end
`ifdef JK_ARB_PRIO_EN
    if (v[0] && (!m_locked || (m_owner != 0 && !m_pre))) r = 4'b0001;
`endif
    return r;
  endfunction

  task automatic model_edge(input logic [3:0] v, input logic [3:0] l,
                            input logic [7:0] op, input logic [11:0] idx);
    logic [3:0] r;
    int g;
    if (m_pend) begin
      case (m_pop)
        2'b01:   m_q[m_pidx] = 1'b0;
        2'b10:   m_q[m_pidx] = 1'b1;
        2'b11:   m_q[m_pidx] = ~m_q[m_pidx];
        default: ;
      endcase
    end
    r = model_ready(v);
    g = -1;
    for (int k = 0; k < 4; k++) if (r[k] && v[k]) g = k;
    m_pend = (g >= 0);
    if (g >= 0) begin
      m_pop  = op[2*g +: 2];
      m_pidx = int'(idx[3*g +: 3]);
      m_gid  = g;
    end
    if (!m_locked) begin
      if (g >= 0) begin
`ifdef JK_ARB_PRIO_EN
        if (g != 0) m_ptr = (g + 1) % 4;
`else
        m_ptr = (g + 1) % 4;
`endif
        if (l[g]) begin
          m_locked = 1; m_owner = g; m_pre = 0;
        end
      end
    end else if (g >= 0 && g != m_owner) begin
      m_pre = 1;
    end else if (g >= 0) begin
      m_pre = 0;
      if (!l[g]) m_locked = 0;
    end else if (!v[m_owner] && !l[m_owner]) begin
      m_locked = 0; m_pre = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check ready, let the edge happen, check registered outputs.
  task automatic step(input logic [3:0] v, input logic [3:0] l,
                      input logic [7:0] op, input logic [11:0] idx);
    @(negedge clk);
    req_valid = v; req_lock = l; req_op = op; req_idx = idx;
    #1;
    check("ready", 32'(req_ready), 32'(model_ready(v)));
    last_ready = req_ready;
    model_edge(v, l, op, idx);
    @(posedge clk);
    #1;
    check("q", 32'(q), 32'(m_q));
    check("busy", 32'(busy), 32'(m_pend));
    check("grant_id", 32'(grant_id), 32'(m_gid));
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = 4'b0; req_lock = 4'b0; req_op = 8'h00; req_idx = 12'h000;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          rst;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [7:0]  op;
    logic [11:0] idx;
    logic [3:0]  er;
    logic [7:0]  eq;
    logic        eb;
    logic [2:0]  eg;
  } vec_t;

  vec_t tbl [8];

  initial begin
    rst_n = 1'b0;
    req_valid = 4'b0; req_lock = 4'b0; req_op = 8'h00; req_idx = 12'h000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", 32'(q), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_gid", 32'(grant_id), 32'h0);
    check("rst_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single SET latency, then four-way round robin filling bits 0..3.
    tbl[0] = '{1'b1, 4'b0001, 4'b0000, 8'h02, 12'h003, 4'b0001, 8'h00, 1'b1, 3'd0};
    tbl[1] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 12'h000, 4'b0000, 8'h08, 1'b0, 3'd0};
    tbl[2] = '{1'b1, 4'b1111, 4'b0000, 8'hAA, 12'h688, 4'b0001, 8'h00, 1'b1, 3'd0};
    tbl[3] = '{1'b0, 4'b1111, 4'b0000, 8'hAA, 12'h688, 4'b0010, 8'h01, 1'b1, 3'd1};
    tbl[4] = '{1'b0, 4'b1111, 4'b0000, 8'hAA, 12'h688, 4'b0100, 8'h03, 1'b1, 3'd2};
    tbl[5] = '{1'b0, 4'b1111, 4'b0000, 8'hAA, 12'h688, 4'b1000, 8'h07, 1'b1, 3'd3};
    tbl[6] = '{1'b0, 4'b1111, 4'b0000, 8'hAA, 12'h688, 4'b0001, 8'h0F, 1'b1, 3'd0};
    tbl[7] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 12'h000, 4'b0000, 8'h0F, 1'b0, 3'd0};
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i].v, tbl[i].l, tbl[i].op, tbl[i].idx);
      check($sformatf("tbl%0d_ready", i), 32'(last_ready), 32'(tbl[i].er));
      check($sformatf("tbl%0d_q", i), 32'(q), 32'(tbl[i].eq));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].eb));
      check($sformatf("tbl%0d_gid", i), 32'(grant_id), 32'(tbl[i].eg));
    end

    // Locked back-to-back toggles of bit 5 by req1; others must wait.
    step(4'b0010, 4'b0010, 8'h0C, 12'h028);
    check("tgl_ready1", 32'(last_ready), 32'h2);
    step(4'b0111, 4'b0000, 8'h0C, 12'h028);
    check("tgl_ready2", 32'(last_ready), 32'h2);
    check("tgl_q5_first", 32'(q[5]), 32'h1);
    step(4'b0101, 4'b0000, 8'h00, 12'h000);
    check("tgl_next_req2", 32'(last_ready), 32'h4);
    check("tgl_q5_second", 32'(q[5]), 32'h0);

    // Owner holds lock while idle: req0/req3 stall; after release req3 wins (pointer 3).
    do_reset();
    step(4'b0100, 4'b0100, 8'h00, 12'h000);
    check("lock_acq", 32'(last_ready), 32'h4);
    for (int i = 0; i < 5; i++) begin
      step(4'b1001, 4'b0100, 8'h00, 12'h000);
      check($sformatf("lock_stall%0d", i), 32'(last_ready), 32'h0);
    end
    step(4'b1001, 4'b0000, 8'h00, 12'h000);
    check("lock_release", 32'(last_ready), 32'h0);
    step(4'b1001, 4'b0000, 8'h00, 12'h000);
    check("lock_ptr3", 32'(last_ready), 32'h8);

    // Reset right after accepting CLR idx0 with the bank full: no stale apply.
    do_reset();
    for (int b = 0; b < 8; b++) step(4'b0001, 4'b0000, 8'h02, 12'(b));
    step(4'b0001, 4'b0000, 8'h01, 12'h000);
    check("rst_pre_q", 32'(q), 32'hFF);
    rst_n = 1'b0;
    #1;
    check("rst_mid_q", 32'(q), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    model_reset();
    req_valid = 4'b0; req_lock = 4'b0; req_op = 8'h00; req_idx = 12'h000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0000, 4'b0000, 8'h00, 12'h000);
    check("rst_no_stale", 32'(q), 32'h0);
    step(4'b1010, 4'b0000, 8'h00, 12'h000);
    check("rst_idle_ptr0", 32'(last_ready), 32'h2);

`ifdef JK_ARB_PRIO_EN
    // Requester 0 preempts req1's lock for one command; req1 stays owner.
    do_reset();
    step(4'b0010, 4'b0010, 8'h00, 12'h000);
    step(4'b0011, 4'b0010, 8'h02, 12'h007);
    check("prio_preempt", 32'(last_ready), 32'h1);
    step(4'b0010, 4'b0010, 8'h00, 12'h000);
    check("prio_owner_resume", 32'(last_ready), 32'h2);
    check("prio_q7", 32'(q[7]), 32'h1);
    step(4'b1001, 4'b0010, 8'h00, 12'h000);
    check("prio_still_locked", 32'(last_ready), 32'h1);
    step(4'b0010, 4'b0000, 8'h00, 12'h000);
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(4'($urandom), 4'($urandom & $urandom), 8'($urandom), 12'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
